rot_seq_ctrl: RTL
=================

# rot_seq_ctrl

Rotation sequencer that turns the programmed image configuration (source address, height, width, mode, direction) into an ordered stream of single-pixel DMA read/write transactions. It sits between the APB register interface and the DMA engine. It consumes the start pulse and soft-reset level from the control registers. It returns the destination base address and the rotated dimensions for read-back through the register interface.

## Interface
- P_PIX_BYTES, 4, byte stride between consecutive pixels (one pixel per DMA word)
- I_ROTCTRL_PCLK  input  1  clock
- I_ROTCTRL_PRESET_N  input  1  asynchronous active-low reset
- I_ROTCTRL_START  input  1  start pulse, sampled only in IDLE
- I_ROTCTRL_SOFT_RESET  input  1  level; synchronous abort to IDLE while high
- I_ROTCTRL_SRC_IMG  input  32  source image byte base address
- I_ROTCTRL_IMG_H / I_ROTCTRL_IMG_W  input  16 each  source height / width in pixels
- I_ROTCTRL_IMG_MODE  input  2  00=0°, 01=90°, 10=180°, 11=270°
- I_ROTCTRL_IMG_DIR  input  1  0=clockwise, 1=counter-clockwise
- O_ROTCTRL_DMA_DST_IMG  output  32  destination base address
- O_ROTCTRL_NEW_H / O_ROTCTRL_NEW_W  output  16 each  rotated height / width
- O_ROTCTRL_RD_REQ  output  1  read request; O_ROTCTRL_RD_ADDR  output  32
- I_ROTCTRL_RD_VALID  input  1  read completes; I_ROTCTRL_RD_DATA  input  32
- O_ROTCTRL_WR_REQ  output  1  write request; O_ROTCTRL_WR_ADDR / O_ROTCTRL_WR_DATA  output  32 each
- I_ROTCTRL_WR_ACK  input  1  write completes
- O_ROTCTRL_BUSY  output  1  job in progress; O_ROTCTRL_DONE  output  1  one-cycle completion pulse

## Operation
- States: IDLE, SETUP, READ, WRITE, DONE.
- IDLE: START=1 and SOFT_RESET=0 → SETUP. Config inputs are latched on that edge and then held internally for the whole job.
- Effective clockwise rotation: rot = DIR ? (4−MODE) mod 4 : MODE.
- SETUP (1 cycle): compute DST_IMG = SRC + P_PIX_BYTES·H·W, all arithmetic mod 2^32.
  - NEW_H/NEW_W = H/W for rot 0 and 2; W/H for rot 1 and 3.
  - Register these outputs; they hold until the next SETUP or reset.
  - Exit: H==0 or W==0 → DONE; otherwise → READ with r=0, c=0.
- Source scan order is raster: row r in 0..H−1, column c in 0..W−1. RD_ADDR = SRC + P_PIX_BYTES·(r·W + c).
- Destination index d by rot:
  - 0: r·W + c
  - 1: c·H + (H−1−r)
  - 2: (H−1−r)·W + (W−1−c)
  - 3: (W−1−c)·H + r
- WR_ADDR = DST_IMG + P_PIX_BYTES·d. The implementation may use incremental counters; multipliers are not required, but results must match these formulas.
- READ: RD_REQ=1 with RD_ADDR stable. On an edge with RD_VALID=1, capture RD_DATA → WRITE.
- WRITE: WR_REQ=1 with WR_ADDR and WR_DATA stable. On an edge with WR_ACK=1:
  - last pixel (r=H−1, c=W−1) → DONE;
  - otherwise advance c (wrapping to c=0, r+1) → READ.
- DONE (1 cycle): DONE=1 → IDLE.
- Only one transaction is outstanding at a time. RD_VALID outside READ and WR_ACK outside WRITE are ignored.
- START outside IDLE is ignored.
- SOFT_RESET=1 in any state → IDLE on the next edge:
  - REQs and BUSY drop; no DONE pulse.
  - NEW_H/NEW_W/DST_IMG are cleared to 0.

## Timing
- Reset values (async and soft): state IDLE; every output 0.
- START sampled at edge 0 → SETUP during cycle 1, BUSY=1 → RD_REQ=1 in cycle 2 at the earliest.
- With RD_VALID and WR_ACK tied high: 2 cycles per pixel. An H·W job is START → DONE pulse in 2 + 2·H·W cycles.
- BUSY=1 in SETUP, READ and WRITE. BUSY=0 in IDLE and DONE.
- A REQ rises on state entry and falls the cycle after the completing edge. ADDR/DATA must not change while REQ=1.
- A START arriving in the DONE cycle is ignored; a new job needs START in IDLE.
- Async reset mid-job aborts immediately; no partial-state recovery.

## Test plan
- SRC=0x1000, H=2, W=3, MODE=01, DIR=0, acks tied high:
  - DST_IMG=0x1018, NEW_H=3, NEW_W=2.
  - RD_ADDR 0x1000..0x1014 step 4.
  - WR_ADDR 0x101C, 0x1024, 0x102C, 0x1018, 0x1020, 0x1028.
  - DONE at cycle 14.
- Same image, MODE=10: WR_ADDR 0x102C, 0x1028, 0x1024, 0x1020, 0x101C, 0x1018; NEW_H=2, NEW_W=3.
- Same image, MODE=01, DIR=1 (≡270° CW): WR_ADDR 0x1028, 0x1020, 0x1018, 0x102C, 0x1024, 0x101C.
- Backpressure: RD_VALID delayed 3 cycles and WR_ACK delayed 2 cycles per pixel → RD_ADDR, WR_ADDR and WR_DATA held constant while REQ high; WR_DATA equals the captured RD_DATA.
- H=0, W=5, START → no REQ ever asserted; DONE pulses in cycle 2; NEW_H=5, NEW_W=0 for MODE=01.
- SOFT_RESET=1 during the third WRITE → next cycle WR_REQ=0, BUSY=0, outputs 0, no DONE. A START during the job is ignored; a START after release runs a full fresh job.

Source files
------------

// File: rtl/rot_seq_ctrl.sv
// Rotation sequencer: walks the source image in raster order and issues one
// single-pixel DMA read then write per pixel, placing each pixel at its rotated slot.
module rot_seq_ctrl #(
  parameter int unsigned P_PIX_BYTES = 4
) (
  input  logic        I_ROTCTRL_PCLK,
  input  logic        I_ROTCTRL_PRESET_N,
  input  logic        I_ROTCTRL_START,
  input  logic        I_ROTCTRL_SOFT_RESET,
  input  logic [31:0] I_ROTCTRL_SRC_IMG,
  input  logic [15:0] I_ROTCTRL_IMG_H,
  input  logic [15:0] I_ROTCTRL_IMG_W,
  input  logic [1:0]  I_ROTCTRL_IMG_MODE,
  input  logic        I_ROTCTRL_IMG_DIR,
  output logic [31:0] O_ROTCTRL_DMA_DST_IMG,
  output logic [15:0] O_ROTCTRL_NEW_H,
  output logic [15:0] O_ROTCTRL_NEW_W,
  output logic        O_ROTCTRL_RD_REQ,
  output logic [31:0] O_ROTCTRL_RD_ADDR,
  input  logic        I_ROTCTRL_RD_VALID,
  input  logic [31:0] I_ROTCTRL_RD_DATA,
  output logic        O_ROTCTRL_WR_REQ,
  output logic [31:0] O_ROTCTRL_WR_ADDR,
  output logic [31:0] O_ROTCTRL_WR_DATA,
  input  logic        I_ROTCTRL_WR_ACK,
  output logic        O_ROTCTRL_BUSY,
  output logic        O_ROTCTRL_DONE
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_READ, S_WRITE, S_DONE} state_t;

  localparam logic [31:0] PIX     = 32'(P_PIX_BYTES);
  localparam logic [31:0] NEG_PIX = 32'd0 - PIX;

  state_t      state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [15:0] h_q, h_d, w_q, w_d;
  logic [1:0]  rot_q, rot_d;
  logic [15:0] r_q, r_d, c_q, c_d;
  logic [31:0] dst_q, dst_d;
  logic [15:0] new_h_q, new_h_d, new_w_q, new_w_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] row_addr_q, row_addr_d;
  logic [31:0] col_step_q, col_step_d;
  logic [31:0] row_step_q, row_step_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic [31:0] hw, pix_h, pix_w, dst_calc;
  logic        last_col, last_pix;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    h_d        = h_q;
    w_d        = w_q;
    rot_d      = rot_q;
    r_d        = r_q;
    c_d        = c_q;
    dst_d      = dst_q;
    new_h_d    = new_h_q;
    new_w_d    = new_w_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    row_addr_d = row_addr_q;
    col_step_d = col_step_q;
    row_step_d = row_step_q;
    wr_data_d  = wr_data_q;

    hw       = {16'd0, h_q} * {16'd0, w_q};
    pix_h    = PIX * {16'd0, h_q};
    pix_w    = PIX * {16'd0, w_q};
    dst_calc = src_q + PIX * hw;
    last_col = (c_q == w_q - 16'd1);
    last_pix = last_col && (r_q == h_q - 16'd1);

    unique case (state_q)
      S_IDLE: begin
        if (I_ROTCTRL_START && !I_ROTCTRL_SOFT_RESET) begin
          src_d   = I_ROTCTRL_SRC_IMG;
          h_d     = I_ROTCTRL_IMG_H;
          w_d     = I_ROTCTRL_IMG_W;
          rot_d   = I_ROTCTRL_IMG_DIR ? (2'd0 - I_ROTCTRL_IMG_MODE) : I_ROTCTRL_IMG_MODE;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        dst_d     = dst_calc;
        rd_addr_d = src_q;
        r_d       = 16'd0;
        c_d       = 16'd0;
        new_h_d   = rot_q[0] ? w_q : h_q;
        new_w_d   = rot_q[0] ? h_q : w_q;
        // Walk the destination with a per-column step and a per-row step from the row's first slot.
        unique case (rot_q)
          2'd0: begin
            row_addr_d = dst_calc;
            col_step_d = PIX;
            row_step_d = pix_w;
          end
          2'd1: begin
            row_addr_d = dst_calc + pix_h - PIX;
            col_step_d = pix_h;
            row_step_d = NEG_PIX;
          end
          2'd2: begin
            row_addr_d = dst_calc + PIX * hw - PIX;
            col_step_d = NEG_PIX;
            row_step_d = 32'd0 - pix_w;
          end
          default: begin
            row_addr_d = dst_calc + PIX * hw - pix_h;
            col_step_d = 32'd0 - pix_h;
            row_step_d = PIX;
          end
        endcase
        wr_addr_d = row_addr_d;
        state_d   = (h_q == 16'd0 || w_q == 16'd0) ? S_DONE : S_READ;
      end
      S_READ: begin
        if (I_ROTCTRL_RD_VALID) begin
          wr_data_d = I_ROTCTRL_RD_DATA;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (I_ROTCTRL_WR_ACK) begin
          if (last_pix) begin
            state_d = S_DONE;
          end else begin
            rd_addr_d = rd_addr_q + PIX;
            if (last_col) begin
              c_d        = 16'd0;
              r_d        = r_q + 16'd1;
              row_addr_d = row_addr_q + row_step_q;
              wr_addr_d  = row_addr_q + row_step_q;
            end else begin
              c_d       = c_q + 16'd1;
              wr_addr_d = wr_addr_q + col_step_q;
            end
            state_d = S_READ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (I_ROTCTRL_SOFT_RESET) begin
      state_d   = S_IDLE;
      dst_d     = 32'd0;
      new_h_d   = 16'd0;
      new_w_d   = 16'd0;
      rd_addr_d = 32'd0;
      wr_addr_d = 32'd0;
      wr_data_d = 32'd0;
    end
  end

  always_ff @(posedge I_ROTCTRL_PCLK or negedge I_ROTCTRL_PRESET_N) begin
    if (!I_ROTCTRL_PRESET_N) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      h_q        <= '0;
      w_q        <= '0;
      rot_q      <= '0;
      r_q        <= '0;
      c_q        <= '0;
      dst_q      <= '0;
      new_h_q    <= '0;
      new_w_q    <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      row_addr_q <= '0;
      col_step_q <= '0;
      row_step_q <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      h_q        <= h_d;
      w_q        <= w_d;
      rot_q      <= rot_d;
      r_q        <= r_d;
      c_q        <= c_d;
      dst_q      <= dst_d;
      new_h_q    <= new_h_d;
      new_w_q    <= new_w_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      row_addr_q <= row_addr_d;
      col_step_q <= col_step_d;
      row_step_q <= row_step_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign O_ROTCTRL_DMA_DST_IMG = dst_q;
  assign O_ROTCTRL_NEW_H       = new_h_q;
  assign O_ROTCTRL_NEW_W       = new_w_q;
  assign O_ROTCTRL_RD_REQ      = (state_q == S_READ);
  assign O_ROTCTRL_RD_ADDR     = rd_addr_q;
  assign O_ROTCTRL_WR_REQ      = (state_q == S_WRITE);
  assign O_ROTCTRL_WR_ADDR     = wr_addr_q;
  assign O_ROTCTRL_WR_DATA     = wr_data_q;
  assign O_ROTCTRL_BUSY        = (state_q == S_SETUP) || (state_q == S_READ) || (state_q == S_WRITE);
  assign O_ROTCTRL_DONE        = (state_q == S_DONE);

endmodule
